// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and the per-source hazard rule for the pipeline stall controller.
// A source stalls when it is needed sooner than a producer in E or M can deliver it.
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE        = 2'd3;
  localparam int         MULT_CYCLES_DEF  = 5;
  localparam int         DIV_CYCLES_DEF   = 10;
  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         STALL_CNT_W      = 32;

  // TUSE_NONE can never be below a 2-bit Tnew, so unused sources drop out naturally.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_a3,
    input logic [1:0] e_tnew,
    input logic [4:0] m_a3,
    input logic [1:0] m_tnew
  );
    logic w_e_hit;
    logic w_m_hit;
    w_e_hit = (src == e_a3) && (tuse < e_tnew);
    w_m_hit = (src == m_a3) && (tuse < m_tnew);
    return (src != REG_ZERO) && (w_e_hit || w_m_hit);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div busy countdown: a load sets the remaining busy cycles, zero is terminal.
// A load always wins over the decrement, so a start while busy reloads.
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard and stall controller: data hazards, mult/div busy interlock,
// and a saturating count of stalled cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_d_rs,
  input  logic [4:0]  i_d_rt,
  input  logic [1:0]  i_d_tuse_rs,
  input  logic [1:0]  i_d_tuse_rt,
  input  logic        i_d_is_md,
  input  logic [4:0]  i_e_a3,
  input  logic [1:0]  i_e_tnew,
  input  logic [4:0]  i_m_a3,
  input  logic [1:0]  i_m_tnew,
  input  logic        i_e_md_start,
  input  logic        i_e_md_div,
  output logic        o_pc_stall,
  output logic        o_d_stall,
  output logic        o_e_flush,
  output logic        o_md_busy,
  output logic [31:0] o_stall_cnt
);

  logic             w_stall_rs;
  logic             w_stall_rt;
  logic             w_stall_md;
  logic             w_stall;
  logic             w_md_busy;
  logic [CNT_W-1:0] w_load_val;
  logic [31:0]      r_stall_cnt;

  assign w_stall_rs = src_hazard(i_d_rs, i_d_tuse_rs, i_e_a3, i_e_tnew, i_m_a3, i_m_tnew);
  assign w_stall_rt = src_hazard(i_d_rt, i_d_tuse_rt, i_e_a3, i_e_tnew, i_m_a3, i_m_tnew);

  // The starting op is still in E this cycle, so the busy flag alone would miss it.
  assign w_stall_md = i_d_is_md && (i_e_md_start || w_md_busy);
  assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

  assign w_load_val = i_e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  md_busy_counter #(
    .CNT_W (CNT_W)
  ) u_md_busy_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (i_e_md_start),
    .i_load_val (w_load_val),
    .i_dec      (1'b1),
    .o_busy     (w_md_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_pc_stall  = w_stall;
  assign o_d_stall   = w_stall;
  assign o_e_flush   = w_stall;
  assign o_md_busy   = w_md_busy;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-indexed reference model.
module tb_hazard_ctrl;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  d_rs = '0, d_rt = '0, e_a3 = '0, m_a3 = '0;
  logic [1:0]  d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, e_tnew = '0, m_tnew = '0;
  logic        d_is_md = 1'b0, e_md_start = 1'b0, e_md_div = 1'b0;
  logic        pc_stall, d_stall, e_flush, md_busy;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: busy is "current cycle index <= last busy cycle"; stall count is a clamped integer.
  int    cyc = 0;
  int    busy_last = -1;
  longint scnt = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_d_rs       (d_rs),
    .i_d_rt       (d_rt),
    .i_d_tuse_rs  (d_tuse_rs),
    .i_d_tuse_rt  (d_tuse_rt),
    .i_d_is_md    (d_is_md),
    .i_e_a3       (e_a3),
    .i_e_tnew     (e_tnew),
    .i_m_a3       (m_a3),
    .i_m_tnew     (m_tnew),
    .i_e_md_start (e_md_start),
    .i_e_md_div   (e_md_div),
    .o_pc_stall   (pc_stall),
    .o_d_stall    (d_stall),
    .o_e_flush    (e_flush),
    .o_md_busy    (md_busy),
    .o_stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit needs_wait(input int src, input int tuse);
    bit from_e, from_m;
    if (src == 0) return 1'b0;
    from_e = (src == int'(e_a3)) && (tuse < int'(e_tnew));
    from_m = (src == int'(m_a3)) && (tuse < int'(m_tnew));
    return from_e || from_m;
  endfunction

  function automatic bit exp_busy();
    return cyc <= busy_last;
  endfunction

  function automatic bit exp_stall();
    bit md;
    md = d_is_md && (e_md_start || exp_busy());
    return needs_wait(int'(d_rs), int'(d_tuse_rs)) || needs_wait(int'(d_rt), int'(d_tuse_rt)) || md;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks all outputs for the current inputs, then advances the model and DUT one cycle.
  task automatic tick();
    bit s;
    #1;
    s = exp_stall();
    check("pc_stall",  {31'd0, pc_stall}, {31'd0, s});
    check("d_stall",   {31'd0, d_stall},  {31'd0, s});
    check("e_flush",   {31'd0, e_flush},  {31'd0, s});
    check("md_busy",   {31'd0, md_busy},  {31'd0, exp_busy()});
    check("stall_cnt", stall_cnt, scnt[31:0]);
    @(posedge clk);
    if (reset) begin
      busy_last = cyc;
      scnt = 0;
    end else begin
      if (s) scnt = (scnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : scnt + 1;
      if (e_md_start) busy_last = cyc + (e_md_div ? N_DIV : N_MULT);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    d_rs = '0; d_rt = '0; e_a3 = '0; m_a3 = '0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; e_tnew = '0; m_tnew = '0;
    d_is_md = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] base;

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_busy", {31'd0, md_busy}, 32'd0);
    check("reset_cnt", stall_cnt, 32'd0);
    tick();

    // Load-use from E: needed now, ready in two cycles
    e_a3 = 5'd1; e_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd0;
    #1 check("lw_e_stall", {31'd0, pc_stall}, 32'd1);
    tick();
    d_tuse_rs = 2'd2;
    #1 check("lw_e_nostall", {31'd0, pc_stall}, 32'd0);
    tick();

    idle();
    m_a3 = 5'd5; m_tnew = 2'd1; d_rt = 5'd5; d_tuse_rt = 2'd0;
    #1 check("m_stall", {31'd0, d_stall}, 32'd1);
    tick();
    d_rt = 5'd0; m_a3 = 5'd0;
    #1 check("m_zero", {31'd0, d_stall}, 32'd0);
    tick();

    // Mult start with an md op waiting in D
    idle();
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (pc_stall) n++;
      tick();
      e_md_start = 1'b0;
    end
    check("mult_stall_len", n, N_MULT + 1);

    // Div busy length, then a second div interrupted by reset
    idle();
    e_md_start = 1'b1; e_md_div = 1'b1;
    tick();
    idle();
    n = 0;
    for (int i = 0; i < N_DIV + 3; i++) begin
      #1;
      if (md_busy) n++;
      tick();
    end
    check("div_busy_len", n, N_DIV);

    e_md_start = 1'b1; e_md_div = 1'b1;
    tick();
    idle();
    tick(); tick(); tick();
    reset = 1'b1;
    e_md_start = 1'b1;
    #1 check("div_busy_before_rst", {31'd0, md_busy}, 32'd1);
    tick();
    reset = 1'b0;
    e_md_start = 1'b0;
    #1 check("div_busy_after_rst", {31'd0, md_busy}, 32'd0);
    tick();

    // Data and md stall together count once per cycle
    e_md_start = 1'b1; e_md_div = 1'b0;
    tick();
    idle();
    base = stall_cnt;
    e_a3 = 5'd7; e_tnew = 2'd2; d_rs = 5'd7; d_tuse_rs = 2'd0; d_is_md = 1'b1;
    tick(); tick(); tick();
    idle();
    #1 check("combo_delta", stall_cnt - base, 32'd3);
    for (int i = 0; i < N_MULT; i++) tick();

    // Saturation
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_stall_cnt;
    scnt = 64'hFFFF_FFFE;
    e_a3 = 5'd3; e_tnew = 2'd1; d_rt = 5'd3; d_tuse_rt = 2'd0;
    tick(); tick(); tick();
    idle();
    #1 check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      e_a3       = 5'($urandom_range(0, 3));
      m_a3       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      e_tnew     = 2'($urandom_range(0, 3));
      m_tnew     = 2'($urandom_range(0, 3));
      d_is_md    = ($urandom_range(0, 2) == 0);
      e_md_start = ($urandom_range(0, 9) == 0);
      e_md_div   = $urandom_range(0, 1) != 0;
      reset      = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. Each cycle it decides whether the D-stage instruction must wait, driving the PC hold, the IF/ID register hold and the ID/EX bubble. It also owns the multiply/divide busy countdown and a saturating stall-cycle performance counter. It sits between the decode stage and the PC, IF/ID and ID/EX registers.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start
- CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- d_rs, d_rt  in  5 each  D-stage source register numbers
- d_tuse_rs, d_tuse_rt  in  2 each  D-stage Tuse; 3 means the register is unused
- d_is_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_a3  in  5  E-stage destination register
- e_tnew  in  2  E-stage Tnew as the instruction enters E
- m_a3  in  5  M-stage destination register
- m_tnew  in  2  M-stage Tnew, already decremented by the pipeline
- e_md_start  in  1  E-stage instruction is mult/multu/div/divu (one cycle)
- e_md_div  in  1  qualifies e_md_start: 1 selects div, 0 selects mult
- pc_stall  out  1  hold PC
- d_stall  out  1  hold IF/ID
- e_flush  out  1  load a bubble into ID/EX
- md_busy  out  1  the mult/div unit is busy
- stall_cnt  out  32  saturating count of stalled cycles

## Operation
- stall_rs = (d_rs != 0) && ((d_rs == e_a3 && d_tuse_rs < e_tnew) || (d_rs == m_a3 && d_tuse_rs < m_tnew)). stall_rt uses the same rule with d_rt and d_tuse_rt.
- Register 0 never causes a stall. Any destination register of 0 is ignored.
- stall_md = d_is_md && (e_md_start || md_busy).
- stall = stall_rs | stall_rt | stall_md. pc_stall, d_stall and e_flush all equal stall. The stall outputs are combinational from the inputs and the busy state.
- Busy counter cnt (CNT_W bits):
  - Loads DIV_CYCLES when e_md_start && e_md_div, and MULT_CYCLES when e_md_start && !e_md_div.
  - Otherwise it decrements when nonzero and holds at 0.
  - md_busy = (cnt != 0).
- The start load has priority over the decrement. A start while busy reloads the counter. This cannot happen in legal operation because stall_md blocks it.
- stall_cnt increments by 1 in every cycle where stall = 1. It saturates at 0xFFFFFFFF and does not wrap.
- The controller has no further state. Forwarding is handled elsewhere.

## Timing
- Reset values: cnt = 0, md_busy = 0, stall_cnt = 0. The stall outputs follow the inputs during reset.
- A mult start in cycle T gives md_busy = 1 from T+1 through T+MULT_CYCLES, and md_busy = 0 at T+MULT_CYCLES+1.
- A D-stage md instruction in cycle T is stalled by e_md_start. It then stays stalled while md_busy is high and is released in the first cycle with md_busy = 0.
- The counter is a pure countdown: 0 is terminal, with no underflow and no wrap.
- If reset is asserted mid-countdown, cnt is 0 on the next cycle and any pending start is discarded.
- Data and md stalls occurring together produce a single stall; stall_cnt adds 1.

## Structure
- A shared package holds:
  - TUSE_NONE = 2'd3
  - the MULT_CYCLES and DIV_CYCLES defaults
  - the register-0 constant
- One sub-module, md_busy_counter, holds the countdown with its load and decrement ports. The remaining logic stays flat in hazard_ctrl.

## Test plan
- lw $1 in E (e_a3=1, e_tnew=2), D reads rs=1 with d_tuse_rs=0 -> stall=1. Same case with d_tuse_rs=2 -> stall=0.
- M-stage conflict: m_a3=5, m_tnew=1, d_rt=5, d_tuse_rt=0 -> stall=1. Same with d_rt=0 and m_a3=0 -> stall=0.
- mult start at cycle 10 with d_is_md=1 held -> stall from cycle 10 through 15 and released at cycle 16. md_busy is high for cycles 11–15.
- div start -> md_busy high for exactly 10 cycles. Assert reset in the 4th busy cycle -> md_busy=0 on the next cycle.
- Force a data stall and an md stall together for 3 cycles -> stall_cnt rises by exactly 3.
- Preload stall_cnt near saturation by forcing it to 0xFFFFFFFE, then stall for 3 cycles -> stall_cnt holds at 0xFFFFFFFF.
